// File: rtl/os_detector_if.sv
`default_nettype none
// =============================================================================
// Module : os_detector_if
// Desc   : PHY receive symbol stream into the detector, LTSSM status out of it.
// Rev    : 1.0  initial release
// =============================================================================
interface os_detector_if #(
  parameter int CNT_W = 4
);
  logic [7:0]       rxdata;
  logic             rxdatak;
  logic             rxvalid;
  logic             cnt_clr;
  logic             ts1_det;
  logic             ts2_det;
  logic             skp_det;
  logic             os_err;
  logic [7:0]       link_num;
  logic [7:0]       lane_num;
  logic [7:0]       n_fts;
  logic [7:0]       rate_id;
  logic [7:0]       train_ctrl;
  logic [CNT_W-1:0] ts1_cnt;
  logic [CNT_W-1:0] ts2_cnt;
  logic             ts1_match;
  logic             ts2_match;

  modport master (
    output rxdata, rxdatak, rxvalid, cnt_clr,
    input  ts1_det, ts2_det, skp_det, os_err,
    input  link_num, lane_num, n_fts, rate_id, train_ctrl,
    input  ts1_cnt, ts2_cnt, ts1_match, ts2_match
  );

  modport slave (
    input  rxdata, rxdatak, rxvalid, cnt_clr,
    output ts1_det, ts2_det, skp_det, os_err,
    output link_num, lane_num, n_fts, rate_id, train_ctrl,
    output ts1_cnt, ts2_cnt, ts1_match, ts2_match
  );
endinterface
`default_nettype wire

// File: rtl/os_detector.sv
`default_nettype none
// =============================================================================
// Module : os_detector
// Desc   : Frames and validates Gen1 TS1/TS2/SKP ordered sets on the RX stream.
// Rev    : 1.0  initial release
// =============================================================================
module os_detector #(
  parameter int MATCH_CNT = 8,
  parameter int CNT_W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  os_detector_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_ID   = 2'd2;
  localparam logic [1:0] S_SKPS = 2'd3;

  localparam logic [7:0] C_COM    = 8'hBC;
  localparam logic [7:0] C_SKP    = 8'h1C;
  localparam logic [7:0] C_PAD    = 8'hF7;
  localparam logic [7:0] C_TS1_ID = 8'h4A;
  localparam logic [7:0] C_TS2_ID = 8'h45;

  logic [1:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] skp_q, skp_d;
  logic [7:0] type_q, type_d;

  logic [7:0] link_sh_q, lane_sh_q, nfts_sh_q, rate_sh_q, ctrl_sh_q;
  logic [7:0] prev1_link_q, prev1_lane_q, prev2_link_q, prev2_lane_q;

  logic             ts1_det_q, ts2_det_q, skp_det_q, os_err_q;
  logic [7:0]       link_q, lane_q, nfts_q, rate_q, ctrl_q;
  logic [CNT_W-1:0] ts1_cnt_q, ts2_cnt_q;

  logic w_is_com, w_is_skp, w_is_pad;
  logic w_restart, w_err, w_ts_ok, w_skp_ok;
  logic w_ts1_ok, w_ts2_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_is_com = bus.rxdatak && (bus.rxdata == C_COM);
  assign w_is_skp = bus.rxdatak && (bus.rxdata == C_SKP);
  assign w_is_pad = bus.rxdatak && (bus.rxdata == C_PAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      skp_q   <= 2'd0;
      type_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      skp_q   <= skp_d;
      type_q  <= type_d;
    end
  end

  // Symbol classification; a COM outside IDLE always wins and restarts framing.
  always_comb begin
    w_restart = 1'b0;
    w_err     = 1'b0;
    w_ts_ok   = 1'b0;
    w_skp_ok  = 1'b0;
    if (bus.rxvalid) begin
      if ((state_q != S_IDLE) && w_is_com) begin
        w_restart = 1'b1;
      end else begin
        case (state_q)
          S_HDR: begin
            if ((idx_q == 4'd1) && w_is_skp)
              w_err = 1'b0;
            else if (idx_q <= 4'd2)
              w_err = bus.rxdatak && !w_is_pad;
            else
              w_err = bus.rxdatak;
          end
          S_ID: begin
            if (idx_q == 4'd6)
              w_err = bus.rxdatak ||
                      ((bus.rxdata != C_TS1_ID) && (bus.rxdata != C_TS2_ID));
            else begin
              w_err   = bus.rxdatak || (bus.rxdata != type_q);
              w_ts_ok = !w_err && (idx_q == 4'd15);
            end
          end
          S_SKPS: begin
            if (w_is_skp)
              w_skp_ok = (skp_q == 2'd2);
            else
              w_err = 1'b1;
          end
          default: w_err = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    skp_d   = skp_q;
    type_d  = type_q;
    if (bus.rxvalid) begin
      if (w_restart) begin
        state_d = S_HDR;
        idx_d   = 4'd1;
      end else if (w_err) begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (w_is_com) begin
              state_d = S_HDR;
              idx_d   = 4'd1;
            end
          end
          S_HDR: begin
            if ((idx_q == 4'd1) && w_is_skp) begin
              state_d = S_SKPS;
              skp_d   = 2'd1;
            end else begin
              idx_d = idx_q + 4'd1;
              if (idx_q == 4'd5)
                state_d = S_ID;
            end
          end
          S_ID: begin
            if (idx_q == 4'd6)
              type_d = bus.rxdata;
            if (idx_q == 4'd15) begin
              state_d = S_IDLE;
              idx_d   = 4'd0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
          S_SKPS: begin
            skp_d = skp_q + 2'd1;
            if (w_skp_ok)
              state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign w_ts1_ok = w_ts_ok && (type_q == C_TS1_ID);
  assign w_ts2_ok = w_ts_ok && (type_q == C_TS2_ID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_sh_q <= 8'h00;
      lane_sh_q <= 8'h00;
      nfts_sh_q <= 8'h00;
      rate_sh_q <= 8'h00;
      ctrl_sh_q <= 8'h00;
    end else if (bus.rxvalid && (state_q == S_HDR) && !w_restart && !w_err) begin
      case (idx_q)
        4'd1:    link_sh_q <= bus.rxdata;
        4'd2:    lane_sh_q <= bus.rxdata;
        4'd3:    nfts_sh_q <= bus.rxdata;
        4'd4:    rate_sh_q <= bus.rxdata;
        4'd5:    ctrl_sh_q <= bus.rxdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts1_det_q <= 1'b0;
      ts2_det_q <= 1'b0;
      skp_det_q <= 1'b0;
      os_err_q  <= 1'b0;
      link_q    <= 8'h00;
      lane_q    <= 8'h00;
      nfts_q    <= 8'h00;
      rate_q    <= 8'h00;
      ctrl_q    <= 8'h00;
    end else begin
      ts1_det_q <= w_ts1_ok;
      ts2_det_q <= w_ts2_ok;
      skp_det_q <= w_skp_ok;
      os_err_q  <= w_err || w_restart;
      if (w_ts_ok) begin
        link_q <= link_sh_q;
        lane_q <= lane_sh_q;
        nfts_q <= nfts_sh_q;
        rate_q <= rate_sh_q;
        ctrl_q <= ctrl_sh_q;
      end
    end
  end

  // A run continues only while link/lane repeat and the other type's run is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts1_cnt_q    <= '0;
      ts2_cnt_q    <= '0;
      prev1_link_q <= 8'h00;
      prev1_lane_q <= 8'h00;
      prev2_link_q <= 8'h00;
      prev2_lane_q <= 8'h00;
    end else begin
      if (w_ts1_ok) begin
        prev1_link_q <= link_sh_q;
        prev1_lane_q <= lane_sh_q;
      end
      if (w_ts2_ok) begin
        prev2_link_q <= link_sh_q;
        prev2_lane_q <= lane_sh_q;
      end
      if (bus.cnt_clr || w_err) begin
        ts1_cnt_q <= '0;
        ts2_cnt_q <= '0;
      end else if (w_ts1_ok) begin
        ts1_cnt_q <= ((link_sh_q == prev1_link_q) && (lane_sh_q == prev1_lane_q) &&
                      (ts2_cnt_q == '0)) ? sat_inc(ts1_cnt_q) : CNT_W'(1);
        ts2_cnt_q <= '0;
      end else if (w_ts2_ok) begin
        ts2_cnt_q <= ((link_sh_q == prev2_link_q) && (lane_sh_q == prev2_lane_q) &&
                      (ts1_cnt_q == '0)) ? sat_inc(ts2_cnt_q) : CNT_W'(1);
        ts1_cnt_q <= '0;
      end
    end
  end

  assign bus.ts1_det    = ts1_det_q;
  assign bus.ts2_det    = ts2_det_q;
  assign bus.skp_det    = skp_det_q;
  assign bus.os_err     = os_err_q;
  assign bus.link_num   = link_q;
  assign bus.lane_num   = lane_q;
  assign bus.n_fts      = nfts_q;
  assign bus.rate_id    = rate_q;
  assign bus.train_ctrl = ctrl_q;
  assign bus.ts1_cnt    = ts1_cnt_q;
  assign bus.ts2_cnt    = ts2_cnt_q;
  assign bus.ts1_match  = (32'(ts1_cnt_q) >= 32'(MATCH_CNT));
  assign bus.ts2_match  = (32'(ts2_cnt_q) >= 32'(MATCH_CNT));

endmodule
`default_nettype wire

// File: tb/tb_os_detector.sv
`default_nettype none
// =============================================================================
// Module : tb_os_detector
// Desc   : Directed self-checking bench for os_detector.
// Rev    : 1.0  initial release
// =============================================================================
module tb_os_detector;

  localparam logic [7:0] C_COM = 8'hBC;
  localparam logic [7:0] C_SKP = 8'h1C;
  localparam logic [7:0] C_PAD = 8'hF7;
  localparam logic [7:0] C_TS1 = 8'h4A;
  localparam logic [7:0] C_TS2 = 8'h45;

  logic clk;
  logic rst;
  int   n_asrt;
  int   n_fail;

  logic [7:0] os_d [16];
  logic       os_k [16];

  os_detector_if #(.CNT_W(4)) bus ();

  os_detector #(.MATCH_CNT(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [53:0] w_all;
  assign w_all = {bus.ts1_det, bus.ts2_det, bus.skp_det, bus.os_err,
                  bus.link_num, bus.lane_num, bus.n_fts, bus.rate_id, bus.train_ctrl,
                  bus.ts1_cnt, bus.ts2_cnt, bus.ts1_match, bus.ts2_match};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one symbol at a falling edge; on return the sampling edge has passed.
  task automatic put(input logic [7:0] d, input logic k);
    bus.rxdata  = d;
    bus.rxdatak = k;
    bus.rxvalid = 1'b1;
    @(negedge clk);
  endtask

  task automatic put_idle();
    bus.rxdata  = C_COM;
    bus.rxdatak = 1'b1;
    bus.rxvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic build_ts(input logic [7:0] id, input logic [7:0] link, input logic lk,
                          input logic [7:0] lane, input logic nk, input logic [7:0] nfts,
                          input logic [7:0] rate, input logic [7:0] ctrl);
    os_d[0] = C_COM; os_k[0] = 1'b1;
    os_d[1] = link;  os_k[1] = lk;
    os_d[2] = lane;  os_k[2] = nk;
    os_d[3] = nfts;  os_k[3] = 1'b0;
    os_d[4] = rate;  os_k[4] = 1'b0;
    os_d[5] = ctrl;  os_k[5] = 1'b0;
    for (int i = 6; i < 16; i++) begin
      os_d[i] = id;
      os_k[i] = 1'b0;
    end
  endtask

  task automatic send(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) put(os_d[i], os_k[i]);
  endtask

  initial begin
    n_asrt      = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.rxdata  = 8'h00;
    bus.rxdatak = 1'b0;
    bus.rxvalid = 1'b0;
    bus.cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(w_all), 64'd0);
    rst = 1'b0;

    // Eight back-to-back TS1
    build_ts(C_TS1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 8'h02, 8'h00);
    for (int n = 1; n <= 8; n++) begin
      send(0, 14);
      if (n == 1) chk("ts1_det_before_idx15", 64'(bus.ts1_det), 64'd0);
      send(15, 15);
      chk("ts1_det", 64'(bus.ts1_det), 64'd1);
      chk("ts1_cnt", 64'(bus.ts1_cnt), 64'(n));
      chk("ts1_match", 64'(bus.ts1_match), 64'(n >= 8));
    end
    chk("n_fts", 64'(bus.n_fts), 64'h10);
    chk("rate_id", 64'(bus.rate_id), 64'h02);
    send(0, 0);
    chk("ts1_det_one_cycle", 64'(bus.ts1_det), 64'd0);
    send(1, 15);

    // Saturation at 15
    for (int n = 10; n <= 16; n++) begin
      send(0, 15);
      if (n >= 15) chk("ts1_cnt_sat", 64'(bus.ts1_cnt), 64'd15);
    end

    // cnt_clr coincident with TS1 completion
    build_ts(C_TS1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h20, 8'h02, 8'h00);
    send(0, 14);
    bus.cnt_clr = 1'b1;
    send(15, 15);
    bus.cnt_clr = 1'b0;
    chk("clr_ts1_det", 64'(bus.ts1_det), 64'd1);
    chk("clr_ts1_cnt", 64'(bus.ts1_cnt), 64'd0);
    chk("clr_n_fts", 64'(bus.n_fts), 64'h20);

    // Build up to five, then a bad ID symbol at idx9
    build_ts(C_TS1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 8'h02, 8'h00);
    for (int n = 0; n < 5; n++) send(0, 15);
    chk("ts1_cnt_5", 64'(bus.ts1_cnt), 64'd5);
    os_d[9] = C_TS2;
    send(0, 8);
    chk("err_not_early", 64'(bus.os_err), 64'd0);
    send(9, 9);
    chk("err_pulse", 64'(bus.os_err), 64'd1);
    chk("err_cnt_clear", 64'(bus.ts1_cnt), 64'd0);
    send(10, 15);
    chk("err_no_det", 64'(bus.ts1_det), 64'd0);
    chk("err_fields_kept", 64'(bus.n_fts), 64'h10);

    // PAD in link and lane
    build_ts(C_TS1, C_PAD, 1'b1, C_PAD, 1'b1, 8'h10, 8'h02, 8'h00);
    send(0, 15);
    chk("pad_det", 64'(bus.ts1_det), 64'd1);
    chk("pad_link", 64'(bus.link_num), 64'hF7);
    chk("pad_lane", 64'(bus.lane_num), 64'hF7);
    chk("pad_cnt", 64'(bus.ts1_cnt), 64'd1);

    // 3 TS1, SKP OS, 1 TS1
    build_ts(C_TS1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 8'h02, 8'h00);
    for (int n = 0; n < 3; n++) send(0, 15);
    chk("pre_skp_cnt", 64'(bus.ts1_cnt), 64'd3);
    put(C_COM, 1'b1);
    put(C_SKP, 1'b1);
    put(C_SKP, 1'b1);
    chk("skp_not_early", 64'(bus.skp_det), 64'd0);
    put(C_SKP, 1'b1);
    chk("skp_det", 64'(bus.skp_det), 64'd1);
    chk("skp_no_err", 64'(bus.os_err), 64'd0);
    chk("skp_cnt_kept", 64'(bus.ts1_cnt), 64'd3);
    chk("skp_link_kept", 64'(bus.link_num), 64'h00);
    send(0, 15);
    chk("post_skp_cnt", 64'(bus.ts1_cnt), 64'd4);

    // COM at idx10 of a TS2, then a full TS2
    build_ts(C_TS2, 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 8'h02, 8'h00);
    send(0, 9);
    put(C_COM, 1'b1);
    chk("restart_err", 64'(bus.os_err), 64'd1);
    send(1, 1);
    chk("restart_err_once", 64'(bus.os_err), 64'd0);
    send(2, 15);
    chk("ts2_det", 64'(bus.ts2_det), 64'd1);
    chk("ts2_cnt_1", 64'(bus.ts2_cnt), 64'd1);
    chk("ts2_clears_ts1", 64'(bus.ts1_cnt), 64'd0);
    send(0, 15);
    chk("ts2_cnt_2", 64'(bus.ts2_cnt), 64'd2);
    chk("ts2_match_low", 64'(bus.ts2_match), 64'd0);

    // rxvalid low for 3 cycles mid-ID, with a COM on the bus meanwhile
    build_ts(C_TS1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 8'h02, 8'h00);
    send(0, 8);
    repeat (3) put_idle();
    chk("gap_no_err", 64'(bus.os_err), 64'd0);
    send(9, 14);
    chk("gap_no_det_early", 64'(bus.ts1_det), 64'd0);
    send(15, 15);
    chk("gap_det", 64'(bus.ts1_det), 64'd1);
    chk("gap_ts1_cnt", 64'(bus.ts1_cnt), 64'd1);
    chk("gap_ts2_cnt", 64'(bus.ts2_cnt), 64'd0);

    // Asynchronous reset at idx12
    send(0, 12);
    rst = 1'b1;
    #1;
    chk("async_reset", 64'(w_all), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    send(0, 0);
    chk("post_reset_no_err", 64'(bus.os_err), 64'd0);
    send(1, 15);
    chk("post_reset_det", 64'(bus.ts1_det), 64'd1);
    chk("post_reset_cnt", 64'(bus.ts1_cnt), 64'd1);

    bus.rxvalid = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
